// File: rtl/nand_cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nand_cpu_pkg
// Description : Shared types and constants for the NAND CPU pipeline control.
// Revision    : 1.0 - initial release
// ============================================================================
package nand_cpu_pkg;

    localparam int         c_REG_W_DEFAULT = 3;
    localparam logic [1:0] c_DRAIN_CYCLES  = 2'd3;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } ctrl_state_e;

    typedef enum logic [1:0] {
        FWD_RF = 2'd0,
        FWD_E  = 2'd1,
        FWD_M  = 2'd2
    } fwd_sel_e;

    // The younger (E) producer always wins over the older (M) one.
    function automatic fwd_sel_e fwd_pick(input logic e_hit, input logic m_hit);
        if (e_hit) begin
            return FWD_E;
        end
        if (m_hit) begin
            return FWD_M;
        end
        return FWD_RF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipeline_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_detect
// Description : Combinational load-use detection and operand forward select.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_detect
    import nand_cpu_pkg::*;
#(
    parameter int REG_W = c_REG_W_DEFAULT
) (
    input  logic             d_rs_valid,
    input  logic [REG_W-1:0] d_rs,
    input  logic             d_rt_valid,
    input  logic [REG_W-1:0] d_rt,
    input  logic             e_rd_valid,
    input  logic [REG_W-1:0] e_rd,
    input  logic             e_is_load,
    input  logic             m_rd_valid,
    input  logic [REG_W-1:0] m_rd,
    output logic             load_use,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b
);

    logic w_e_alu;
    logic w_e_load;

    // A load result is not available in E, so it can never be forwarded from there.
    assign w_e_alu  = e_rd_valid && !e_is_load;
    assign w_e_load = e_rd_valid &&  e_is_load;

    assign load_use = w_e_load && ((d_rs_valid && (d_rs == e_rd)) ||
                                   (d_rt_valid && (d_rt == e_rd)));

    assign fwd_a = fwd_pick(w_e_alu && (e_rd == d_rs), m_rd_valid && (m_rd == d_rs));
    assign fwd_b = fwd_pick(w_e_alu && (e_rd == d_rt), m_rd_valid && (m_rd == d_rt));

endmodule
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline stall/flush sequencer with memory-wait, drain and halt.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
    import nand_cpu_pkg::*;
#(
    parameter int REG_W       = c_REG_W_DEFAULT,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d_rs_valid,
    input  logic [REG_W-1:0] d_rs,
    input  logic             d_rt_valid,
    input  logic [REG_W-1:0] d_rt,
    input  logic             e_rd_valid,
    input  logic [REG_W-1:0] e_rd,
    input  logic             e_is_load,
    input  logic             m_rd_valid,
    input  logic [REG_W-1:0] m_rd,
    input  logic             e_branch_taken,
    input  logic             d_halt,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_stall,
    output logic             i2d_stall,
    output logic             i2d_flush,
    output logic             d2e_stall,
    output logic             d2e_flush,
    output logic             e2m_stall,
    output logic             m2w_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             halted,
    output logic             mem_error,
    output logic [15:0]      stall_cycles
);

    localparam int                  c_WAIT_W    = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MEM_TIMEOUT - 1);

    ctrl_state_e         r_state;
    logic [c_WAIT_W-1:0] r_wait_cnt;
    logic [1:0]          r_drain_cnt;
    logic                r_halted;
    logic                r_mem_error;
    logic [15:0]         r_stall_cycles;

    logic       w_load_use;
    logic [1:0] w_fwd_a;
    logic [1:0] w_fwd_b;
    logic       w_live, w_mem_busy, w_mem_stall, w_branch, w_load_stall, w_halt_go;
    logic       w_pc_stall, w_i2d_stall, w_i2d_flush, w_d2e_stall, w_d2e_flush;
    logic       w_e2m_stall, w_m2w_bubble;

    pipeline_hazard_detect #(
        .REG_W (REG_W)
    ) u_hazard (
        .d_rs_valid (d_rs_valid),
        .d_rs       (d_rs),
        .d_rt_valid (d_rt_valid),
        .d_rt       (d_rt),
        .e_rd_valid (e_rd_valid),
        .e_rd       (e_rd),
        .e_is_load  (e_is_load),
        .m_rd_valid (m_rd_valid),
        .m_rd       (m_rd),
        .load_use   (w_load_use),
        .fwd_a      (w_fwd_a),
        .fwd_b      (w_fwd_b)
    );

    // MEM_WAIT with the memory ready behaves exactly like RUN.
    assign w_live       = (r_state == ST_RUN) || (r_state == ST_MEM_WAIT);
    assign w_mem_busy   = mem_req && !mem_ready;
    assign w_mem_stall  = w_live && w_mem_busy;
    assign w_branch     = e_branch_taken && !w_mem_busy && (w_live || (r_state == ST_DRAIN));
    assign w_load_stall = w_live && !w_mem_busy && !e_branch_taken && w_load_use;
    assign w_halt_go    = w_live && !w_mem_busy && !e_branch_taken && !w_load_use && d_halt;

    always_comb begin
        w_pc_stall   = 1'b0;
        w_i2d_stall  = 1'b0;
        w_i2d_flush  = 1'b0;
        w_d2e_stall  = 1'b0;
        w_d2e_flush  = 1'b0;
        w_e2m_stall  = 1'b0;
        w_m2w_bubble = 1'b0;
        if (!rst) begin
            case (r_state)
                ST_HALTED: begin
                    w_pc_stall   = 1'b1;
                    w_i2d_stall  = 1'b1;
                    w_d2e_stall  = 1'b1;
                    w_e2m_stall  = 1'b1;
                    w_m2w_bubble = 1'b1;
                end
                ST_DRAIN: begin
                    w_pc_stall  = !w_branch;
                    w_i2d_flush = 1'b1;
                    w_d2e_flush = w_branch;
                    // Older instructions still in flight must not advance past a busy memory.
                    w_d2e_stall  = w_mem_busy;
                    w_e2m_stall  = w_mem_busy;
                    w_m2w_bubble = w_mem_busy;
                end
                default: begin
                    if (w_mem_stall) begin
                        w_pc_stall   = 1'b1;
                        w_i2d_stall  = 1'b1;
                        w_d2e_stall  = 1'b1;
                        w_e2m_stall  = 1'b1;
                        w_m2w_bubble = 1'b1;
                    end else if (w_branch) begin
                        w_i2d_flush = 1'b1;
                        w_d2e_flush = 1'b1;
                    end else if (w_load_stall) begin
                        w_pc_stall  = 1'b1;
                        w_i2d_stall = 1'b1;
                        w_d2e_flush = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state        <= ST_RUN;
            r_wait_cnt     <= '0;
            r_drain_cnt    <= '0;
            r_halted       <= 1'b0;
            r_mem_error    <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            if (w_pc_stall && (r_state != ST_HALTED) && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
            case (r_state)
                ST_RUN, ST_MEM_WAIT: begin
                    if (w_mem_stall) begin
                        if (r_wait_cnt == c_WAIT_LAST) begin
                            r_state     <= ST_HALTED;
                            r_wait_cnt  <= '0;
                            r_mem_error <= 1'b1;
                            r_halted    <= 1'b1;
                        end else begin
                            r_state    <= ST_MEM_WAIT;
                            r_wait_cnt <= r_wait_cnt + c_WAIT_W'(1);
                        end
                    end else begin
                        r_wait_cnt <= '0;
                        if (w_halt_go) begin
                            r_state     <= ST_DRAIN;
                            r_drain_cnt <= c_DRAIN_CYCLES;
                        end else begin
                            r_state <= ST_RUN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (w_branch) begin
                        r_state     <= ST_RUN;
                        r_drain_cnt <= '0;
                    end else if (!w_mem_busy) begin
                        if (r_drain_cnt == 2'd1) begin
                            r_state     <= ST_HALTED;
                            r_drain_cnt <= '0;
                            r_halted    <= 1'b1;
                        end else begin
                            r_drain_cnt <= r_drain_cnt - 2'd1;
                        end
                    end
                end
                ST_HALTED: begin
                    r_state <= ST_HALTED;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    assign pc_stall     = w_pc_stall;
    assign i2d_stall    = w_i2d_stall;
    assign i2d_flush    = w_i2d_flush;
    assign d2e_stall    = w_d2e_stall;
    assign d2e_flush    = w_d2e_flush;
    assign e2m_stall    = w_e2m_stall;
    assign m2w_bubble   = w_m2w_bubble;
    assign fwd_a        = rst ? 2'd0 : w_fwd_a;
    assign fwd_b        = rst ? 2'd0 : w_fwd_b;
    assign halted       = r_halted;
    assign mem_error    = r_mem_error;
    assign stall_cycles = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed self-checking bench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

    localparam int REG_W = 3;

    // {pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, m2w_bubble}
    localparam logic [6:0] c_IDLE     = 7'b000_0000;
    localparam logic [6:0] c_MEMSTALL = 7'b110_1011;
    localparam logic [6:0] c_BRANCH   = 7'b001_0100;
    localparam logic [6:0] c_LOADUSE  = 7'b110_0100;
    localparam logic [6:0] c_DRAIN    = 7'b101_0000;
    localparam logic [6:0] c_HALTED   = 7'b110_1011;

    logic             clk = 1'b0;
    logic             rst;
    logic             d_rs_valid, d_rt_valid, e_rd_valid, e_is_load, m_rd_valid;
    logic [REG_W-1:0] d_rs, d_rt, e_rd, m_rd;
    logic             e_branch_taken, d_halt, mem_req, mem_ready;
    logic             pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, m2w_bubble;
    logic [1:0]       fwd_a, fwd_b;
    logic             halted, mem_error;
    logic [15:0]      stall_cycles;
    logic [6:0]       ctrl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipeline_ctrl #(
        .REG_W       (REG_W),
        .MEM_TIMEOUT (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .d_rs_valid     (d_rs_valid),
        .d_rs           (d_rs),
        .d_rt_valid     (d_rt_valid),
        .d_rt           (d_rt),
        .e_rd_valid     (e_rd_valid),
        .e_rd           (e_rd),
        .e_is_load      (e_is_load),
        .m_rd_valid     (m_rd_valid),
        .m_rd           (m_rd),
        .e_branch_taken (e_branch_taken),
        .d_halt         (d_halt),
        .mem_req        (mem_req),
        .mem_ready      (mem_ready),
        .pc_stall       (pc_stall),
        .i2d_stall      (i2d_stall),
        .i2d_flush      (i2d_flush),
        .d2e_stall      (d2e_stall),
        .d2e_flush      (d2e_flush),
        .e2m_stall      (e2m_stall),
        .m2w_bubble     (m2w_bubble),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b),
        .halted         (halted),
        .mem_error      (mem_error),
        .stall_cycles   (stall_cycles)
    );

    assign ctrl = {pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, m2w_bubble};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        d_rs_valid = 1'b0; d_rs = '0;
        d_rt_valid = 1'b0; d_rt = '0;
        e_rd_valid = 1'b0; e_rd = '0; e_is_load = 1'b0;
        m_rd_valid = 1'b0; m_rd = '0;
        e_branch_taken = 1'b0; d_halt = 1'b0;
        mem_req = 1'b0; mem_ready = 1'b1;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        idle_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        // Reset must mask outputs even with hazards presented on the inputs
        idle_inputs();
        rst = 1'b1;
        mem_req = 1'b1; mem_ready = 1'b0;
        e_rd_valid = 1'b1; e_rd = 3'd1; d_rs_valid = 1'b1; d_rs = 3'd1;
        settle();
        check_eq("rst_ctrl", ctrl, c_IDLE);
        check_eq("rst_fwd_a", fwd_a, 2'd0);
        check_eq("rst_halted", halted, 1'b0);
        check_eq("rst_mem_error", mem_error, 1'b0);
        check_eq("rst_stall_cycles", stall_cycles, 16'd0);
        next_cycle();
        check_eq("rst_hold_ctrl", ctrl, c_IDLE);
        rst = 1'b0;
        idle_inputs();

        // Load-use on source A
        e_is_load = 1'b1; e_rd_valid = 1'b1; e_rd = 3'd3; d_rs_valid = 1'b1; d_rs = 3'd3;
        settle();
        check_eq("lu_ctrl", ctrl, c_LOADUSE);
        check_eq("lu_fwd_a", fwd_a, 2'd0);
        next_cycle();
        idle_inputs();
        settle();
        check_eq("lu_once", ctrl, c_IDLE);
        check_eq("lu_stall_cnt", stall_cycles, 16'd1);
        // Matching but invalid source is not a hazard; source B is
        e_is_load = 1'b1; e_rd_valid = 1'b1; e_rd = 3'd3; d_rs = 3'd3;
        settle();
        check_eq("lu_invalid_src", ctrl, c_IDLE);
        d_rt_valid = 1'b1; d_rt = 3'd3;
        settle();
        check_eq("lu_rt", ctrl, c_LOADUSE);
        next_cycle();
        idle_inputs();

        // Forwarding
        e_rd_valid = 1'b1; e_rd = 3'd2; m_rd_valid = 1'b1; m_rd = 3'd2;
        d_rt_valid = 1'b1; d_rt = 3'd2; d_rs_valid = 1'b1; d_rs = 3'd5;
        settle();
        check_eq("fwd_b_e", fwd_b, 2'd1);
        check_eq("fwd_a_rf", fwd_a, 2'd0);
        check_eq("fwd_ctrl", ctrl, c_IDLE);
        e_rd_valid = 1'b0;
        settle();
        check_eq("fwd_b_m", fwd_b, 2'd2);
        e_rd_valid = 1'b1; e_is_load = 1'b1; d_rs = 3'd2;
        settle();
        check_eq("fwd_a_load_m", fwd_a, 2'd2);
        check_eq("fwd_load_ctrl", ctrl, c_LOADUSE);
        next_cycle();
        idle_inputs();

        // Priority: branch beats load-use and halt; no drain afterwards
        e_branch_taken = 1'b1; d_halt = 1'b1;
        e_is_load = 1'b1; e_rd_valid = 1'b1; e_rd = 3'd4; d_rs_valid = 1'b1; d_rs = 3'd4;
        settle();
        check_eq("prio_branch", ctrl, c_BRANCH);
        next_cycle();
        idle_inputs();
        settle();
        check_eq("prio_no_drain", ctrl, c_IDLE);
        next_cycle();

        // Memory wait of 4 cycles
        reset_dut();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("memwait_c%0d", i), ctrl, c_MEMSTALL);
            next_cycle();
        end
        mem_ready = 1'b1;
        settle();
        check_eq("memwait_release", ctrl, c_IDLE);
        next_cycle();
        idle_inputs();
        settle();
        check_eq("memwait_stall_cnt", stall_cycles, 16'd4);
        check_eq("memwait_run", ctrl, c_IDLE);

        // Branch during memory stall waits for the stall to clear
        mem_req = 1'b1; mem_ready = 1'b0; e_branch_taken = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            check_eq($sformatf("br_stall_c%0d", i), ctrl, c_MEMSTALL);
            next_cycle();
        end
        mem_ready = 1'b1;
        settle();
        check_eq("br_after_stall", ctrl, c_BRANCH);
        next_cycle();
        idle_inputs();
        settle();
        check_eq("br_after_idle", ctrl, c_IDLE);

        // Wrong-path halt: branch in 2nd drain cycle
        reset_dut();
        d_halt = 1'b1;
        settle();
        check_eq("drain_br_h0", ctrl, c_IDLE);
        next_cycle();
        idle_inputs();
        settle();
        check_eq("drain_br_h1", ctrl, c_DRAIN);
        next_cycle();
        e_branch_taken = 1'b1;
        settle();
        check_eq("drain_br_h2", ctrl, c_BRANCH);
        next_cycle();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            settle();
            check_eq($sformatf("drain_br_run%0d", i), ctrl, c_IDLE);
            check_eq($sformatf("drain_br_halted%0d", i), halted, 1'b0);
            next_cycle();
        end

        // Full drain to HALTED, 4 cycles after the halt
        d_halt = 1'b1;
        next_cycle();
        idle_inputs();
        for (int i = 1; i <= 3; i++) begin
            settle();
            check_eq($sformatf("drain_h%0d_ctrl", i), ctrl, c_DRAIN);
            check_eq($sformatf("drain_h%0d_halted", i), halted, 1'b0);
            next_cycle();
        end
        e_branch_taken = 1'b1; d_halt = 1'b1;
        settle();
        check_eq("drain_h4_halted", halted, 1'b1);
        check_eq("drain_h4_ctrl", ctrl, c_HALTED);
        check_eq("drain_h4_mem_error", mem_error, 1'b0);
        check_eq("drain_h4_stall_cnt", stall_cycles, 16'd4);
        next_cycle();
        next_cycle();
        settle();
        check_eq("halted_sticky", halted, 1'b1);
        check_eq("halted_cnt_frozen", stall_cycles, 16'd4);

        // Reset mid-drain abandons the drain with no residual flush
        reset_dut();
        d_halt = 1'b1;
        next_cycle();
        idle_inputs();
        settle();
        check_eq("rstdrain_pre", ctrl, c_DRAIN);
        rst = 1'b1;
        settle();
        check_eq("rstdrain_async", ctrl, c_IDLE);
        next_cycle();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            settle();
            check_eq($sformatf("rstdrain_run%0d", i), ctrl, c_IDLE);
            next_cycle();
        end
        check_eq("rstdrain_halted", halted, 1'b0);

        // Memory timeout after 8 waiting cycles
        reset_dut();
        mem_req = 1'b1; mem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            check_eq($sformatf("tmo_c%0d_ctrl", i), ctrl, c_MEMSTALL);
            check_eq($sformatf("tmo_c%0d_halted", i), halted, 1'b0);
            next_cycle();
        end
        settle();
        check_eq("tmo_halted", halted, 1'b1);
        check_eq("tmo_mem_error", mem_error, 1'b1);
        check_eq("tmo_stall_cnt", stall_cycles, 16'd8);
        mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        settle();
        check_eq("tmo_sticky_err", mem_error, 1'b1);
        check_eq("tmo_sticky_ctrl", ctrl, c_HALTED);

        reset_dut();
        settle();
        check_eq("final_halted", halted, 1'b0);
        check_eq("final_mem_error", mem_error, 1'b0);
        check_eq("final_stall_cnt", stall_cycles, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 SHALL have parameter REG_W, default 3, register-address width.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, maximum memory-wait cycles before error.
REQ-003 SHALL have ports, in this order:
- clk  in  1  sole clock.
- rst  in  1  asynchronous, active-high reset.
- d_rs_valid / d_rs  in  1 / REG_W  decode-stage source A.
- d_rt_valid / d_rt  in  1 / REG_W  decode-stage source B.
- e_rd_valid / e_rd / e_is_load  in  1 / REG_W / 1  execute-stage destination.
- m_rd_valid / m_rd  in  1 / REG_W  memory-stage destination.
- e_branch_taken  in  1  redirect resolved in execute.
- d_halt  in  1  halt instruction in decode.
- mem_req / mem_ready  in  1 / 1  memory-stage access handshake.
- pc_stall, i2d_stall, i2d_flush, d2e_stall, d2e_flush, e2m_stall, m2w_bubble  out  1 each  pipeline-register controls.
- fwd_a / fwd_b  out  2 / 2  operand forward select: 0 = regfile, 1 = E, 2 = M.
- halted / mem_error  out  1 / 1  sticky status.
- stall_cycles  out  16  saturating stall counter.

Function
REQ-004 SHALL implement FSM states RUN, MEM_WAIT, DRAIN, HALTED.
REQ-005 SHALL assert memory stall combinationally when mem_req && !mem_ready, in RUN or MEM_WAIT.
- Effect: pc_stall, i2d_stall, d2e_stall, e2m_stall = 1; m2w_bubble = 1.
REQ-006 SHALL move RUN->MEM_WAIT on memory stall, and MEM_WAIT->RUN on the first cycle mem_ready=1.
REQ-007 SHALL count MEM_WAIT cycles; on reaching MEM_TIMEOUT, set mem_error=1 and move to HALTED.
REQ-008 SHALL detect load-use when e_is_load && e_rd_valid && e_rd matches a valid decode source.
- Effect: pc_stall=1, i2d_stall=1, d2e_flush=1 for that cycle only; no state change.
REQ-009 SHALL, when e_branch_taken=1 in RUN with no memory stall, assert i2d_flush=1 and d2e_flush=1 in the same cycle, with pc_stall=0.
REQ-010 SHALL ignore e_branch_taken during a memory stall; the held E stage re-presents it afterwards.
REQ-011 SHALL give priority: memory stall > branch flush > load-use > halt.
REQ-012 SHALL, on d_halt=1 in RUN when no higher-priority event is present, move to DRAIN with the drain counter loaded to 3.
REQ-013 SHALL, in DRAIN, hold pc_stall=1 and i2d_flush=1 and decrement the counter each cycle not memory-stalled; counter 0 -> HALTED.
REQ-014 SHALL, on e_branch_taken=1 in DRAIN (wrong-path halt), flush as REQ-009 and return to RUN.
REQ-015 SHALL, in HALTED, hold all stall outputs=1, all flush outputs=0, m2w_bubble=1, halted=1, until rst.
REQ-016 SHALL set fwd_a and fwd_b combinationally:
- 1 if e_rd_valid && !e_is_load && e_rd matches the source;
- else 2 if m_rd_valid && m_rd matches;
- else 0.
- E match has priority over M.
REQ-017 SHALL increment stall_cycles on each cycle with pc_stall=1 outside HALTED, saturating at 16'hFFFF.
REQ-018 SHALL keep every output free of combinational dependence on state transitions occurring in the same cycle.

Reset
REQ-019 SHALL, while rst=1, force: state RUN; all stall, flush and bubble outputs 0; fwd 0; halted 0; mem_error 0; stall_cycles 0; internal counters 0.
REQ-020 SHALL, on rst asserted mid-MEM_WAIT or mid-DRAIN, abandon the operation immediately, with no residual flush.

Structure
REQ-021 SHALL take ctrl_state_e, fwd_sel_e and REG_W default from shared package nand_cpu_pkg.
REQ-022 SHALL place load-use detection and forwarding logic (REQ-008, REQ-016) in combinational sub-module pipeline_hazard_detect.

Verification
REQ-023 SHALL cover load-use: e_is_load=1, e_rd=3, d_rs=3 valid -> one cycle of pc_stall=1, i2d_stall=1, d2e_flush=1; fwd_a=0.
REQ-024 SHALL cover forwarding: e_rd=2 ALU op, m_rd=2, d_rt=2 -> fwd_b=1; with e_rd_valid=0 -> fwd_b=2.
REQ-025 SHALL cover memory wait: mem_req=1, mem_ready low for 4 cycles -> all stalls 1 for 4 cycles; RUN on the 5th; stall_cycles=4.
REQ-026 SHALL cover timeout: MEM_TIMEOUT=8, mem_ready held 0 -> mem_error=1 and halted=1 after 8 cycles, sticky.
REQ-027 SHALL cover halt drain: d_halt=1 in RUN -> halted=1 exactly 4 cycles later; with e_branch_taken=1 in the 2nd DRAIN cycle -> flushes, back to RUN, halted stays 0.
REQ-028 SHALL cover branch under stall: e_branch_taken=1 during mem stall -> no flush; flush on the cycle mem_ready=1 clears the stall.
